// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_pkg
// Brief    : Shared defaults and state encoding for the TDM demux sequencer
// Revision : 1.0
// ============================================================================
package tdm_demux_pkg;

    localparam int c_N_CH_DEF = 4;
    localparam int c_DW_DEF   = 8;
    localparam int c_FCW_DEF  = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'b00;
    localparam state_t c_ST_FILL = 2'b01;
    localparam state_t c_ST_FULL = 2'b10;

endpackage
`default_nettype wire

// File: rtl/tdm_demux_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_sequencer_if
// Brief    : Word-stream handshake and channel-output bundle of the sequencer
// Revision : 1.0
// ============================================================================
interface tdm_demux_sequencer_if
    import tdm_demux_pkg::*;
#(
    parameter int N_CH = c_N_CH_DEF,
    parameter int DW   = c_DW_DEF,
    parameter int FCW  = c_FCW_DEF
);
    localparam int SW = $clog2(N_CH);

    logic                 in_valid;
    logic [DW-1:0]        in_data;
    logic                 in_sof;
    logic                 in_ready;
    logic                 frame_ack;
    logic [SW-1:0]        sel;
    logic [N_CH*DW-1:0]   ch_data;
    logic [N_CH-1:0]      ch_valid;
    logic                 frame_done;
    logic [FCW-1:0]       frame_cnt;
    logic                 resync_err;

    modport master (
        output in_valid, in_data, in_sof, frame_ack,
        input  in_ready, sel, ch_data, ch_valid, frame_done, frame_cnt, resync_err
    );

    modport slave (
        input  in_valid, in_data, in_sof, frame_ack,
        output in_ready, sel, ch_data, ch_valid, frame_done, frame_cnt, resync_err
    );

endinterface
`default_nettype wire

// File: rtl/tdm_sel_counter.sv
`default_nettype none
// ============================================================================
// Module   : tdm_sel_counter
// Brief    : Mod-N_CH channel select counter with clear and load-to-1
// Revision : 1.0
// ============================================================================
module tdm_sel_counter #(
    parameter int N_CH = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      i_clr,
    input  wire logic                      i_load1,
    input  wire logic                      i_inc,
    output logic [$clog2(N_CH)-1:0]        o_cnt
);
    localparam int SW = $clog2(N_CH);
    localparam logic [SW-1:0] c_LAST = SW'(N_CH - 1);

    logic [SW-1:0] r_cnt;

    // Clear dominates so a completing frame always leaves sel at channel 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= SW'(1);
        end else if (i_inc) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + SW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/tdm_demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_sequencer
// Brief    : Round-robin TDM demultiplexer into registered channel outputs
// Revision : 1.0
// ============================================================================
module tdm_demux_sequencer
    import tdm_demux_pkg::*;
#(
    parameter int N_CH = c_N_CH_DEF,
    parameter int DW   = c_DW_DEF,
    parameter int FCW  = c_FCW_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    tdm_demux_sequencer_if.slave   bus
);
    localparam int SW = $clog2(N_CH);
    localparam logic [SW-1:0] c_LAST_CH = SW'(N_CH - 1);

    state_t               r_state;
    logic                 r_in_ready;
    logic [N_CH-1:0]      r_ch_valid;
    logic                 r_frame_done;
    logic                 r_resync_err;
    logic [FCW-1:0]       r_frame_cnt;

    logic [SW-1:0]        w_sel;
    logic [SW-1:0]        w_target;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_resync;
    logic                 w_clr_sel;
    logic [N_CH-1:0]      w_onehot;
    logic [N_CH*DW-1:0]   w_ch_data;

    assign w_xfer    = bus.in_valid && r_in_ready;
    assign w_target  = bus.in_sof ? '0 : w_sel;
    assign w_last    = w_xfer && (w_target == c_LAST_CH);
    assign w_resync  = w_xfer && bus.in_sof && (r_state == c_ST_FILL) && (w_sel != '0);
    assign w_clr_sel = w_last || (r_state == c_ST_FULL);
    assign w_onehot  = N_CH'(1) << w_target;

    tdm_sel_counter #(
        .N_CH (N_CH)
    ) u_sel_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr_sel),
        .i_load1 (w_xfer && bus.in_sof),
        .i_inc   (w_xfer),
        .o_cnt   (w_sel)
    );

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            logic [DW-1:0] r_word;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else if (w_xfer && (w_target == SW'(k))) begin
                    r_word <= bus.in_data;
                end
            end

            assign w_ch_data[k*DW +: DW] = r_word;
        end
    endgenerate

    // in_ready is computed from the state being left, so leaving FULL costs
    // one extra cycle before the next word can be accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_in_ready   <= 1'b0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_resync_err <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_ch_valid   <= w_xfer ? w_onehot : '0;
            r_frame_done <= w_last;
            r_resync_err <= w_resync;
            if (w_last) begin
                r_frame_cnt <= r_frame_cnt + FCW'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_state <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (w_last) begin
                        r_state    <= c_ST_FULL;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                c_ST_FULL: begin
                    r_in_ready <= 1'b0;
                    if (bus.frame_ack) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.sel        = w_sel;
    assign bus.ch_data    = w_ch_data;
    assign bus.ch_valid   = r_ch_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.resync_err = r_resync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_sequencer
// Brief    : Self-checking bench: vector table, corner sequences, random vs model
// Revision : 1.0
// ============================================================================
module tb_tdm_demux_sequencer;

    localparam int N_CH = 4;
    localparam int DW   = 8;
    localparam int FCW  = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tdm_demux_sequencer_if #(.N_CH(N_CH), .DW(DW), .FCW(FCW)) bus ();

    tdm_demux_sequencer #(
        .N_CH (N_CH),
        .DW   (DW),
        .FCW  (FCW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: channel contents, next channel position, frame-pending flag.
    logic [DW-1:0]   m_ch [N_CH];
    int              m_pos   = 0;
    bit              m_full  = 1'b0;
    bit              m_ready = 1'b0;
    int              m_cnt   = 0;
    logic [N_CH-1:0] m_cv    = '0;
    bit              m_done  = 1'b0;
    bit              m_err   = 1'b0;

    typedef struct {
        bit          rst;
        bit          v;
        logic [7:0]  d;
        bit          sof;
        bit          ack;
        bit          e_rdy;
        logic [1:0]  e_sel;
        logic [3:0]  e_cv;
        bit          e_done;
        bit          e_err;
        logic [3:0]  e_cnt;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(bit rst, bit v, logic [7:0] d, bit sof, bit ack,
                                bit rdy, logic [1:0] sel, logic [3:0] cv, bit done,
                                bit err, logic [3:0] cnt, logic [31:0] data);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.sof = sof; r.ack = ack;
        r.e_rdy = rdy; r.e_sel = sel; r.e_cv = cv; r.e_done = done;
        r.e_err = err; r.e_cnt = cnt; r.e_data = data;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit rst, bit v, logic [DW-1:0] d, bit sof, bit ack);
        bit was_full;
        int t;
        m_cv   = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) m_ch[i] = '0;
            m_pos   = 0;
            m_full  = 1'b0;
            m_ready = 1'b0;
            m_cnt   = 0;
            return;
        end
        was_full = m_full;
        if (v && m_ready) begin
            t        = sof ? 0 : m_pos;
            m_err    = sof && (m_pos != 0);
            m_ch[t]  = d;
            m_cv[t]  = 1'b1;
            if (t == N_CH - 1) begin
                m_done = 1'b1;
                m_cnt  = (m_cnt + 1) % (1 << FCW);
                m_full = 1'b1;
                m_pos  = 0;
            end else begin
                m_pos = t + 1;
            end
        end else if (m_full && ack) begin
            m_full = 1'b0;
        end
        m_ready = !(was_full || m_done);
    endfunction

    task automatic check_model();
        logic [N_CH*DW-1:0] exp_data;
        for (int i = 0; i < N_CH; i++) exp_data[i*DW +: DW] = m_ch[i];
        check("mdl.in_ready",   64'(bus.in_ready),   64'(m_ready));
        check("mdl.sel",        64'(bus.sel),        64'(m_pos));
        check("mdl.ch_data",    64'(bus.ch_data),    64'(exp_data));
        check("mdl.ch_valid",   64'(bus.ch_valid),   64'(m_cv));
        check("mdl.frame_done", 64'(bus.frame_done), 64'(m_done));
        check("mdl.frame_cnt",  64'(bus.frame_cnt),  64'(m_cnt));
        check("mdl.resync_err", 64'(bus.resync_err), 64'(m_err));
    endtask

    // Inputs change just after a falling edge; outputs are sampled at the next one.
    task automatic cycle(bit rst, bit v, logic [DW-1:0] d, bit sof, bit ack);
        rst_n         = rst;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sof    = sof;
        bus.frame_ack = ack;
        @(posedge clk);
        model_step(rst, v, d, sof, ack);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int last_done;
        int frames;
        int cyc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.frame_ack = 1'b0;

        // reset, full frame, backpressure, ack, resync
        for (int i = 0; i < 3; i++)
            tbl[i] = mk(0,1,8'h11,0,0, 0,2'd0,4'b0000,0,0,4'd0,32'h00000000);
        tbl[3]  = mk(1,0,8'h00,0,0, 1,2'd0,4'b0000,0,0,4'd0,32'h00000000);
        tbl[4]  = mk(1,1,8'hA0,1,0, 1,2'd1,4'b0001,0,0,4'd0,32'h000000A0);
        tbl[5]  = mk(1,1,8'hA1,0,0, 1,2'd2,4'b0010,0,0,4'd0,32'h0000A1A0);
        tbl[6]  = mk(1,1,8'hA2,0,0, 1,2'd3,4'b0100,0,0,4'd0,32'h00A2A1A0);
        tbl[7]  = mk(1,1,8'hA3,0,0, 0,2'd0,4'b1000,1,0,4'd1,32'hA3A2A1A0);
        for (int i = 8; i < 13; i++)
            tbl[i] = mk(1,1,8'hFF,0,0, 0,2'd0,4'b0000,0,0,4'd1,32'hA3A2A1A0);
        tbl[13] = mk(1,0,8'h00,0,1, 0,2'd0,4'b0000,0,0,4'd1,32'hA3A2A1A0);
        tbl[14] = mk(1,0,8'h00,0,0, 1,2'd0,4'b0000,0,0,4'd1,32'hA3A2A1A0);
        tbl[15] = mk(1,1,8'hB0,0,0, 1,2'd1,4'b0001,0,0,4'd1,32'hA3A2A1B0);
        tbl[16] = mk(1,1,8'hB1,0,0, 1,2'd2,4'b0010,0,0,4'd1,32'hA3A2B1B0);
        tbl[17] = mk(1,1,8'hC0,1,0, 1,2'd1,4'b0001,0,1,4'd1,32'hA3A2B1C0);
        tbl[18] = mk(1,0,8'h00,0,0, 1,2'd1,4'b0000,0,0,4'd1,32'hA3A2B1C0);

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].sof, tbl[i].ack);
            check($sformatf("tbl[%0d].in_ready", i),   64'(bus.in_ready),   64'(tbl[i].e_rdy));
            check($sformatf("tbl[%0d].sel", i),        64'(bus.sel),        64'(tbl[i].e_sel));
            check($sformatf("tbl[%0d].ch_valid", i),   64'(bus.ch_valid),   64'(tbl[i].e_cv));
            check($sformatf("tbl[%0d].frame_done", i), 64'(bus.frame_done), 64'(tbl[i].e_done));
            check($sformatf("tbl[%0d].resync_err", i), 64'(bus.resync_err), 64'(tbl[i].e_err));
            check($sformatf("tbl[%0d].frame_cnt", i),  64'(bus.frame_cnt),  64'(tbl[i].e_cnt));
            check($sformatf("tbl[%0d].ch_data", i),    64'(bus.ch_data),    64'(tbl[i].e_data));
        end

        // frame counter wrap with frame_ack tied high
        cycle(0, 0, 8'h00, 0, 0);
        last_done = -1;
        frames    = 0;
        cyc       = 0;
        while (frames < 16 && cyc < 200) begin
            cycle(1, 1, 8'(cyc), 0, 1);
            cyc++;
            if (bus.frame_done) begin
                if (last_done >= 0)
                    check("wrap.frame_period", 64'(cyc - last_done), 64'(N_CH + 2));
                last_done = cyc;
                frames++;
            end
        end
        check("wrap.frames_seen", 64'(frames), 64'd16);
        check("wrap.frame_cnt",   64'(bus.frame_cnt), 64'd0);

        // reset in the middle of a frame
        cycle(0, 0, 8'h00, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        cycle(1, 1, 8'h5A, 0, 0);
        cycle(1, 1, 8'h5B, 0, 0);
        check("midrst.sel_before", 64'(bus.sel), 64'd2);
        cycle(0, 1, 8'h5C, 0, 1);
        check("midrst.sel",        64'(bus.sel),        64'd0);
        check("midrst.ch_data",    64'(bus.ch_data),    64'd0);
        check("midrst.frame_cnt",  64'(bus.frame_cnt),  64'd0);
        check("midrst.frame_done", 64'(bus.frame_done), 64'd0);
        check("midrst.in_ready",   64'(bus.in_ready),   64'd0);

        // randomized traffic against the reference model
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 9) < 7,
                  8'($urandom),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
